// File: rtl/ram_dump_pkg.sv
// Purpose : shared types and constants for the RAM-readout-to-UART dump path.
// Latency : n/a (declarations only).
// Backpr. : n/a.
// Contents: FSM state enum, bytes-per-word helper, 8N1 frame constants.
package ram_dump_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ARM,
      ST_RD,
      ST_WAIT,
      ST_TX,
      ST_DONE
   } state_t;

   localparam logic UART_START_BIT  = 1'b0;
   localparam logic UART_STOP_BIT   = 1'b1;
   localparam int   UART_DATA_BITS  = 8;
   localparam int   UART_FRAME_BITS = UART_DATA_BITS + 2;

   // Number of 8-bit lanes needed to carry one RAM word.
   function automatic int bytes_per_word(input int data_w);
      return (data_w + 7) / 8;
   endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// Purpose : 8N1 serialiser for one byte per send strobe.
// Latency : tx drops to the start bit on the edge that accepts send.
// Backpr. : send is accepted only while ready=1; ready rises in the last stop-bit cycle so frames chain gap-free.
// Ports   : clk, reset (async active-low), send, data[7:0] in; tx (idle high), ready out.
module uart_tx_byte
   import ram_dump_pkg::*;
#(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       send,
   input  logic [7:0] data,
   output logic       tx,
   output logic       ready
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);

   logic [UART_FRAME_BITS-1:0] r_shift;
   logic [3:0]                 r_bit_cnt;
   logic [CNT_W-1:0]           r_clk_cnt;
   logic                       r_busy;
   logic                       w_bit_end;
   logic                       w_frame_end;

   assign w_bit_end   = (r_clk_cnt == CNT_W'(CLKS_PER_BIT - 1));
   assign w_frame_end = r_busy && w_bit_end && (r_bit_cnt == 4'(UART_FRAME_BITS - 1));
   assign ready       = !r_busy || w_frame_end;
   // Bit 0 of the shift register is the line; idle shifts in ones.
   assign tx          = r_shift[0];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_shift   <= '1;
         r_bit_cnt <= '0;
         r_clk_cnt <= '0;
         r_busy    <= 1'b0;
      end else if (send && ready) begin
         r_shift   <= {UART_STOP_BIT, data, UART_START_BIT};
         r_bit_cnt <= '0;
         r_clk_cnt <= '0;
         r_busy    <= 1'b1;
      end else if (r_busy) begin
         if (w_bit_end) begin
            r_clk_cnt <= '0;
            r_shift   <= {1'b1, r_shift[UART_FRAME_BITS-1:1]};
            if (r_bit_cnt == 4'(UART_FRAME_BITS - 1)) begin
               r_busy <= 1'b0;
            end else begin
               r_bit_cnt <= r_bit_cnt + 4'd1;
            end
         end else begin
            r_clk_cnt <= r_clk_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/ram_dump_uart.sv
// Purpose : on a start rising edge, read RAM over [first..last] (wrapping) and send each word as 8N1 bytes.
// Latency : first start bit leaves 2 + ARM_DELAY + RAM_LAT cycles after the trigger edge.
// Backpr. : none upstream; bytes are paced by the serialiser's ready, RAM reads are one-cycle strobes.
// Ports   : clk, reset (async active-low), start, first_addr, last_addr, ram_data in;
//           ram_rd_en, ram_addr, uart_tx, busy, done out.
module ram_dump_uart
   import ram_dump_pkg::*;
#(
   parameter int DATA_W       = 16,
   parameter int ADDR_W       = 6,
   parameter int CLKS_PER_BIT = 434,
   parameter int ARM_DELAY    = 15,
   parameter int RAM_LAT      = 1,
   parameter int MSB_FIRST    = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] first_addr,
   input  logic [ADDR_W-1:0] last_addr,
   output logic              ram_rd_en,
   output logic [ADDR_W-1:0] ram_addr,
   input  logic [DATA_W-1:0] ram_data,
   output logic              uart_tx,
   output logic              busy,
   output logic              done
);

   localparam int BPW    = bytes_per_word(DATA_W);
   localparam int WORD_W = BPW * 8;
   localparam int ARM_W  = (ARM_DELAY > 1) ? $clog2(ARM_DELAY + 1) : 1;
   localparam int LAT_W  = (RAM_LAT > 1) ? $clog2(RAM_LAT) : 1;

   state_t              r_state;
   logic                r_start_q;
   logic [ADDR_W-1:0]   r_cur;
   logic [ADDR_W-1:0]   r_end;
   logic [ARM_W-1:0]    r_arm_cnt;
   logic [LAT_W-1:0]    r_wait_cnt;
   logic [2:0]          r_byte_idx;
   logic [WORD_W-1:0]   r_word;
   logic                r_rd_en;
   logic [ADDR_W-1:0]   r_ram_addr;
   logic                r_busy;
   logic                r_done;

   logic                w_trig;
   logic [WORD_W-1:0]   w_ram_pad;
   logic                w_last_wait;
   logic                w_more;
   logic                w_send;
   logic [7:0]          w_send_byte;
   logic                w_tx_ready;

   // Lane idx of the word in transmit order.
   function automatic logic [7:0] pick(input logic [WORD_W-1:0] w, input logic [2:0] idx);
      logic [7:0] b;
      b = '0;
      for (int k = 0; k < BPW; k++) begin
         if ((MSB_FIRST != 0) ? (k == BPW - 1 - int'(idx)) : (k == int'(idx))) begin
            b = w[k*8 +: 8];
         end
      end
      return b;
   endfunction

   // Short words are zero-extended so the top lane carries zero high bits.
   always_comb begin
      w_ram_pad               = '0;
      w_ram_pad[DATA_W-1:0]   = ram_data;
   end

   assign w_trig      = start && !r_start_q;
   assign w_last_wait = (r_state == ST_WAIT) && (r_wait_cnt == LAT_W'(RAM_LAT - 1));
   assign w_more      = (r_byte_idx < 3'(BPW - 1));
   // The first byte goes straight from the RAM bus so its start bit lands on the capture edge;
   // later bytes come from the held word, one lane ahead of the current index.
   assign w_send      = w_last_wait || ((r_state == ST_TX) && w_tx_ready && w_more);
   assign w_send_byte = (r_state == ST_WAIT) ? pick(w_ram_pad, 3'd0)
                                             : pick(r_word, r_byte_idx + 3'd1);

   uart_tx_byte #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_tx (
      .clk   (clk),
      .reset (reset),
      .send  (w_send),
      .data  (w_send_byte),
      .tx    (uart_tx),
      .ready (w_tx_ready)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state    <= ST_IDLE;
         r_start_q  <= 1'b0;
         r_cur      <= '0;
         r_end      <= '0;
         r_arm_cnt  <= '0;
         r_wait_cnt <= '0;
         r_byte_idx <= '0;
         r_word     <= '0;
         r_rd_en    <= 1'b0;
         r_ram_addr <= '0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_start_q <= start;
         case (r_state)
            ST_IDLE, ST_DONE: begin
               if (w_trig) begin
                  r_cur     <= first_addr;
                  r_end     <= last_addr;
                  r_arm_cnt <= '0;
                  r_busy    <= 1'b1;
                  r_done    <= 1'b0;
                  r_state   <= ST_ARM;
               end
            end
            ST_ARM: begin
               if (r_arm_cnt == ARM_W'(ARM_DELAY)) begin
                  r_rd_en    <= 1'b1;
                  r_ram_addr <= r_cur;
                  r_state    <= ST_RD;
               end else begin
                  r_arm_cnt <= r_arm_cnt + ARM_W'(1);
               end
            end
            ST_RD: begin
               r_rd_en    <= 1'b0;
               r_wait_cnt <= '0;
               r_state    <= ST_WAIT;
            end
            ST_WAIT: begin
               if (w_last_wait) begin
                  r_word     <= w_ram_pad;
                  r_byte_idx <= '0;
                  r_state    <= ST_TX;
               end else begin
                  r_wait_cnt <= r_wait_cnt + LAT_W'(1);
               end
            end
            ST_TX: begin
               // ready here means the current stop bit is in its final cycle.
               if (w_tx_ready) begin
                  if (w_more) begin
                     r_byte_idx <= r_byte_idx + 3'd1;
                  end else if (r_cur == r_end) begin
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                     r_state <= ST_DONE;
                  end else begin
                     r_cur      <= r_cur + ADDR_W'(1);
                     r_ram_addr <= r_cur + ADDR_W'(1);
                     r_rd_en    <= 1'b1;
                     r_state    <= ST_RD;
                  end
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign ram_rd_en = r_rd_en;
   assign ram_addr  = r_ram_addr;
   assign busy      = r_busy;
   assign done      = r_done;

endmodule

// File: tb/tb_ram_dump_uart.sv
// Purpose : directed self-checking bench for ram_dump_uart across three parameter sets.
// Latency : n/a.
// Backpr. : n/a.
module tb_ram_dump_uart;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [2:0]  start;
   logic [5:0]  first_a [3];
   logic [5:0]  last_a  [3];
   logic [5:0]  addr    [3];
   logic [2:0]  rd_en, tx, busy, done;
   logic [15:0] rdat [3];
   logic [15:0] mem  [64];
   logic [15:0] p0   [3];
   logic [15:0] p1   [3];

   int cyc = 0;
   int total = 0, bad = 0, ferr = 0;
   int rxq[$], rx_t[$], rd_log[$];
   bit          m_act [3];
   int          m_n   [3];
   logic [9:0]  m_sh  [3];
   int t0, td, rb, xb, tb0;
   int ew [8];

   initial forever #5 clk = ~clk;

   // Instance 0: default parameters.
   ram_dump_uart u_a (
      .clk(clk), .reset(rst_n), .start(start[0]), .first_addr(first_a[0]), .last_addr(last_a[0]),
      .ram_rd_en(rd_en[0]), .ram_addr(addr[0]), .ram_data(rdat[0]), .uart_tx(tx[0]),
      .busy(busy[0]), .done(done[0]));

   // Instance 1: 12-bit words, LSB lane first.
   ram_dump_uart #(.DATA_W(12), .ADDR_W(6), .CLKS_PER_BIT(4), .ARM_DELAY(2), .RAM_LAT(1), .MSB_FIRST(0)) u_b (
      .clk(clk), .reset(rst_n), .start(start[1]), .first_addr(first_a[1]), .last_addr(last_a[1]),
      .ram_rd_en(rd_en[1]), .ram_addr(addr[1]), .ram_data(rdat[1][11:0]), .uart_tx(tx[1]),
      .busy(busy[1]), .done(done[1]));

   // Instance 2: no arming delay, two-cycle RAM, fast bit clock.
   ram_dump_uart #(.DATA_W(16), .ADDR_W(6), .CLKS_PER_BIT(4), .ARM_DELAY(0), .RAM_LAT(2), .MSB_FIRST(1)) u_c (
      .clk(clk), .reset(rst_n), .start(start[2]), .first_addr(first_a[2]), .last_addr(last_a[2]),
      .ram_rd_en(rd_en[2]), .ram_addr(addr[2]), .ram_data(rdat[2]), .uart_tx(tx[2]),
      .busy(busy[2]), .done(done[2]));

   assign rdat[0] = p0[0];
   assign rdat[1] = p0[1];
   assign rdat[2] = p1[2];

   function automatic int cpb(input int g);
      return (g == 0) ? 434 : 4;
   endfunction

   // RAM model: data is only valid exactly RAM_LAT cycles after the strobe, poison otherwise.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      for (int g = 0; g < 3; g++) begin
         p0[g] <= (rd_en[g] === 1'b1) ? mem[addr[g]] : 16'hDEAD;
         p1[g] <= p0[g];
         if (rd_en[g] === 1'b1) rd_log.push_back(g * 64 + int'(addr[g]));
      end
   end

   // UART receivers: sample each bit at its midpoint, log {instance, byte} and start-bit cycle.
   always @(negedge clk) begin
      for (int g = 0; g < 3; g++) begin
         if (rst_n !== 1'b1) begin
            m_act[g] <= 1'b0;
         end else if (!m_act[g]) begin
            if (tx[g] === 1'b0) begin
               m_act[g] <= 1'b1;
               m_n[g]   <= 0;
               rx_t.push_back(cyc);
            end
         end else begin
            m_n[g] <= m_n[g] + 1;
            if ((m_n[g] + 1) % cpb(g) == cpb(g) / 2) m_sh[g][(m_n[g] + 1) / cpb(g)] <= tx[g];
            if (m_n[g] + 1 == 9 * cpb(g) + cpb(g) / 2) begin
               m_act[g] <= 1'b0;
               rxq.push_back(g * 256 + int'(m_sh[g][8:1]));
               if (tx[g] !== 1'b1 || m_sh[g][0] !== 1'b0) ferr <= ferr + 1;
            end
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int rxb(input int i);
      return (i < rxq.size()) ? rxq[i] : -1;
   endfunction
   function automatic int rdl(input int i);
      return (i < rd_log.size()) ? rd_log[i] : -1;
   endfunction
   function automatic int rxt(input int i);
      return (i < rx_t.size()) ? rx_t[i] : -1;
   endfunction

   task automatic mark();
      rb  = rd_log.size();
      xb  = rxq.size();
      tb0 = rx_t.size();
   endtask

   task automatic trig(input int g, input string tag);
      start[g] = 1'b1;
      t0 = cyc;
      @(negedge clk);
      chk({tag, " busy after trigger"}, 32'(busy[g]), 1);
      chk({tag, " done cleared"}, 32'(done[g]), 0);
   endtask

   task automatic wait_done(input int g, input int lim, input string tag);
      int i;
      i = 0;
      while (done[g] !== 1'b1 && i < lim) begin
         @(negedge clk);
         i++;
      end
      td = cyc;
      chk({tag, " done"}, 32'(done[g]), 1);
      chk({tag, " busy low"}, 32'(busy[g]), 0);
   endtask

   initial begin
      for (int i = 0; i < 64; i++) mem[i] = 16'(i * 257);
      mem[0]  = 16'h0ABC;
      mem[1]  = 16'hBEEF;
      mem[3]  = 16'hA55A;
      mem[5]  = 16'hC33C;
      mem[62] = 16'h1234;
      mem[63] = 16'h5678;
      rst_n = 1'b0;
      start = '0;
      for (int g = 0; g < 3; g++) begin
         first_a[g] = '0;
         last_a[g]  = '0;
      end
      repeat (3) @(negedge clk);
      chk("reset tx", 32'(tx[0]), 1);
      chk("reset rd_en", 32'(rd_en[0]), 0);
      chk("reset addr", 32'(addr[0]), 0);
      chk("reset busy", 32'(busy[0]), 0);
      chk("reset done", 32'(done[0]), 0);
      chk("reset tx fast", 32'(tx[2]), 1);
      rst_n = 1'b1;
      @(negedge clk);

      // Default parameters: one word, MSB lane first.
      first_a[0] = 6'd3; last_a[0] = 6'd3;
      mark();
      trig(0, "A");
      wait_done(0, 9000, "A");
      chk("A done time", td - t0, 8699);
      chk("A reads", rd_log.size() - rb, 1);
      chk("A read addr", rdl(rb), 3);
      chk("A frames", rxq.size() - xb, 2);
      chk("A byte0", rxb(xb), 8'hA5);
      chk("A byte1", rxb(xb + 1), 8'h5A);
      chk("A first start bit", rxt(tb0) - t0, 19);
      chk("A back to back", rxt(tb0 + 1) - rxt(tb0), 4340);
      start[0] = 1'b0;

      // 12-bit word, LSB lane first, zero-padded top lane.
      first_a[1] = 6'd0; last_a[1] = 6'd0;
      mark();
      trig(1, "B");
      wait_done(1, 200, "B");
      chk("B done time", td - t0, 86);
      chk("B read addr", rdl(rb), 64);
      chk("B byte0", rxb(xb), 256 + 8'hBC);
      chk("B byte1", rxb(xb + 1), 256 + 8'h0A);
      chk("B first start bit", rxt(tb0) - t0, 6);
      start[1] = 1'b0;

      // Zero arming delay, two-cycle RAM: start bit four edges after the trigger edge.
      first_a[2] = 6'd3; last_a[2] = 6'd3;
      mark();
      trig(2, "C");
      wait_done(2, 200, "C");
      chk("C first start bit", rxt(tb0) - t0, 5);
      chk("C back to back", rxt(tb0 + 1) - rxt(tb0), 40);
      chk("C done time", td - t0, 85);
      chk("C byte0", rxb(xb), 512 + 8'hA5);
      chk("C byte1", rxb(xb + 1), 512 + 8'h5A);
      start[2] = 1'b0;
      repeat (2) @(negedge clk);

      // Wrapping window; window inputs change after the trigger and must be ignored.
      first_a[2] = 6'd62; last_a[2] = 6'd1;
      mark();
      trig(2, "wrap");
      first_a[2] = 6'd10; last_a[2] = 6'd10;
      wait_done(2, 1000, "wrap");
      chk("wrap reads", rd_log.size() - rb, 4);
      chk("wrap addr0", rdl(rb), 128 + 62);
      chk("wrap addr1", rdl(rb + 1), 128 + 63);
      chk("wrap addr2", rdl(rb + 2), 128 + 0);
      chk("wrap addr3", rdl(rb + 3), 128 + 1);
      chk("wrap frames", rxq.size() - xb, 8);
      ew = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h0A, 8'hBC, 8'hBE, 8'hEF};
      for (int i = 0; i < 8; i++) chk($sformatf("wrap byte%0d", i), rxb(xb + i), 512 + ew[i]);
      start[2] = 1'b0;
      repeat (2) @(negedge clk);

      // Start edges during TX and a held-high start must not retrigger.
      first_a[2] = 6'd5; last_a[2] = 6'd5;
      mark();
      trig(2, "retrig");
      for (int i = 0; i < 50 && rx_t.size() <= tb0; i++) @(negedge clk);
      repeat (10) @(negedge clk);
      start[2] = 1'b0;
      repeat (3) @(negedge clk);
      start[2] = 1'b1;
      wait_done(2, 300, "retrig");
      repeat (20) @(negedge clk);
      chk("retrig single read", rd_log.size() - rb, 1);
      chk("retrig frames", rxq.size() - xb, 2);
      chk("retrig held done", 32'(done[2]), 1);
      chk("retrig byte0", rxb(xb), 512 + 8'hC3);
      chk("retrig byte1", rxb(xb + 1), 512 + 8'h3C);
      start[2] = 1'b0;
      repeat (2) @(negedge clk);
      trig(2, "second dump");
      wait_done(2, 300, "second dump");
      chk("second dump reads", rd_log.size() - rb, 2);
      chk("second dump frames", rxq.size() - xb, 4);
      chk("second dump byte", rxb(xb + 2), 512 + 8'hC3);
      start[2] = 1'b0;
      repeat (2) @(negedge clk);

      // Reset during data bit 0 of the second byte (0x34, bit 0 is low).
      first_a[2] = 6'd62; last_a[2] = 6'd1;
      mark();
      trig(2, "rst");
      for (int i = 0; i < 200 && cyc < t0 + 50; i++) @(negedge clk);
      chk("rst pre tx low", 32'(tx[2]), 0);
      chk("rst pre busy", 32'(busy[2]), 1);
      rst_n = 1'b0;
      start[2] = 1'b0;
      #1;
      chk("rst tx high", 32'(tx[2]), 1);
      chk("rst busy low", 32'(busy[2]), 0);
      chk("rst addr zero", 32'(addr[2]), 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      mark();
      trig(2, "restart");
      wait_done(2, 1000, "restart");
      chk("restart reads", rd_log.size() - rb, 4);
      chk("restart first addr", rdl(rb), 128 + 62);
      chk("restart frames", rxq.size() - xb, 8);
      chk("restart first byte", rxb(xb), 512 + 8'h12);
      chk("restart last byte", rxb(xb + 7), 512 + 8'hEF);
      chk("stop/start bit errors", ferr, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
